// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with bypassed combinational reads, a synchronous
// write-back port and a per-register busy scoreboard that generates the issue stall.
module regfile_scoreboard #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_RD*AW-1:0]    rs_addr_i,
   input  logic [NUM_RD-1:0]       rs_used_i,
   output logic [NUM_RD*WIDTH-1:0] rdata_o,
   input  logic                    issue_valid_i,
   input  logic                    issue_wr_i,
   input  logic [AW-1:0]           issue_rd_i,
   output logic                    issue_ready_o,
   input  logic                    wb_valid_i,
   input  logic [AW-1:0]           wb_rd_i,
   input  logic [WIDTH-1:0]        wb_data_i,
   input  logic                    flush_i,
   output logic [DEPTH-1:0]        busy_vec_o,
   output logic [AW:0]             pending_cnt_o,
   output logic                    wb_err_o
);

   localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};
   localparam bit            BYP_EN   = (BYPASS != 32'sd0);

   logic [WIDTH-1:0] rf_q [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [AW:0]      pending_q;
   logic [AW:0]      pending_d;
   logic             wb_err_q;
   logic             wb_err_d;

   logic [NUM_RD-1:0] haz_s;
   logic              waw_s;
   logic              ready_s;
   logic              fire_s;
   logic              set_en_s;
   logic              clr_en_s;
   logic              inc_s;
   logic              dec_s;

   // Per-port read mux and RAW hazard detection.
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    addr_s;
      logic             byp_s;
      logic [WIDTH-1:0] rd_s;

      assign addr_s = rs_addr_i[gi*AW +: AW];
      assign byp_s  = BYP_EN && wb_valid_i && (wb_rd_i == addr_s);

      // Register 0 reads as zero, then bypass, then the array.
      always_comb begin
         if (addr_s == REG_ZERO) begin
            rd_s = {WIDTH{1'b0}};
         end else if (byp_s) begin
            rd_s = wb_data_i;
         end else begin
            rd_s = rf_q[addr_s];
         end
      end

      assign rdata_o[gi*WIDTH +: WIDTH] = rd_s;
      assign haz_s[gi] = rs_used_i[gi] && (addr_s != REG_ZERO) && busy_q[addr_s] && !byp_s;
   end

   // A pending producer of the destination only stalls if it is not retiring now.
   assign waw_s = issue_wr_i && (issue_rd_i != REG_ZERO) && busy_q[issue_rd_i]
                  && !(wb_valid_i && (wb_rd_i == issue_rd_i));

   assign ready_s  = !flush_i && !(|haz_s) && !waw_s;
   assign fire_s   = issue_valid_i && ready_s;
   assign set_en_s = fire_s && issue_wr_i && (issue_rd_i != REG_ZERO);
   assign clr_en_s = wb_valid_i && (wb_rd_i != REG_ZERO);

   // Scoreboard next state; the set is applied after the clear so a new producer wins.
   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = {DEPTH{1'b0}};
      end else begin
         if (clr_en_s) begin
            busy_d[wb_rd_i] = 1'b0;
         end else begin
            busy_d = busy_q;
         end
         if (set_en_s) begin
            busy_d[issue_rd_i] = 1'b1;
         end else begin
            busy_d[0] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   assign inc_s = set_en_s && !busy_q[issue_rd_i];
   assign dec_s = clr_en_s && busy_q[wb_rd_i] && !(set_en_s && (issue_rd_i == wb_rd_i));

   // Incremental occupancy count that tracks popcount(busy_q).
   always_comb begin
      if (flush_i) begin
         pending_d = {(AW+1){1'b0}};
      end else begin
         pending_d = pending_q + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
      end
   end

   // Sticky flag for a write-back to a register that has no pending producer.
   always_comb begin
      if (clr_en_s && !busy_q[wb_rd_i] && !flush_i) begin
         wb_err_d = 1'b1;
      end else begin
         wb_err_d = wb_err_q;
      end
   end

   // Register array write; register 0 is never written.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            rf_q[i] <= {WIDTH{1'b0}};
         end
      end else if (clr_en_s) begin
         rf_q[wb_rd_i] <= wb_data_i;
      end
   end

   // Scoreboard, count and error flag state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q    <= {DEPTH{1'b0}};
         pending_q <= {(AW+1){1'b0}};
         wb_err_q  <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
         wb_err_q  <= wb_err_d;
      end
   end

   assign issue_ready_o = ready_s;
   assign busy_vec_o    = busy_q;
   assign pending_cnt_o = pending_q;
   assign wb_err_o      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: directed stimulus queues expected values, a negedge monitor
// pops and compares them against a bypassing and a non-bypassing instance.
module tb_regfile_scoreboard;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   localparam int K_RD0    = 0;
   localparam int K_RD1    = 1;
   localparam int K_READY  = 2;
   localparam int K_BUSY   = 3;
   localparam int K_PEND   = 4;
   localparam int K_ERR    = 5;
   localparam int K_RDY_NB = 6;
   localparam int K_RD0_NB = 7;

   localparam int WATCHDOG_CYCLES = 2000;

   logic               clk = 1'b0;
   logic               rst;
   logic [NRD*AW-1:0]  rs_addr;
   logic [NRD-1:0]     rs_used;
   logic               issue_valid, issue_wr, wb_valid, flush;
   logic [AW-1:0]      issue_rd, wb_rd;
   logic [WIDTH-1:0]   wb_data;

   logic [NRD*WIDTH-1:0] rdata, rdata_nb;
   logic                 ready, ready_nb;
   logic [DEPTH-1:0]     busy, busy_nb;
   logic [AW:0]          pend, pend_nb;
   logic                 err, err_nb;

   int checks   = 0;
   int failures = 0;
   bit done     = 1'b0;

   int          kind_q[$];
   logic [31:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NRD), .BYPASS(1)) dut (
      .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_used_i(rs_used), .rdata_o(rdata),
      .issue_valid_i(issue_valid), .issue_wr_i(issue_wr), .issue_rd_i(issue_rd),
      .issue_ready_o(ready), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .flush_i(flush), .busy_vec_o(busy), .pending_cnt_o(pend), .wb_err_o(err));

   regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NRD), .BYPASS(0)) dut_nb (
      .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_used_i(rs_used), .rdata_o(rdata_nb),
      .issue_valid_i(issue_valid), .issue_wr_i(issue_wr), .issue_rd_i(issue_rd),
      .issue_ready_o(ready_nb), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .flush_i(flush), .busy_vec_o(busy_nb), .pending_cnt_o(pend_nb), .wb_err_o(err_nb));

   function automatic logic [31:0] sample(input int k);
      case (k)
         K_RD0:    return rdata[31:0];
         K_RD1:    return rdata[63:32];
         K_READY:  return {31'd0, ready};
         K_BUSY:   return busy;
         K_PEND:   return {26'd0, pend};
         K_ERR:    return {31'd0, err};
         K_RDY_NB: return {31'd0, ready_nb};
         K_RD0_NB: return rdata_nb[31:0];
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_v(input int k, input logic [31:0] v, input string n);
      kind_q.push_back(k);
      exp_q.push_back(v);
      name_q.push_back(n);
   endtask

   task automatic check_now(input logic [31:0] a, input logic [31:0] e, input string n);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; rs_addr = '0; rs_used = '0;
      issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
   endtask

   task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rs_addr = {a1, a0};
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd;
   endtask

   // Monitor: every queued expectation is compared at the falling edge.
   always @(negedge clk) begin
      while (kind_q.size() > 0) begin
         int          k;
         logic [31:0] e, a;
         string       n;
         k = kind_q.pop_front();
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = sample(k);
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", n, a, e);
         end
      end
   end

   // Watchdog: fails the run if the directed sequence does not finish in time.
   initial begin : watchdog
      int cycles;
      cycles = 0;
      while (!done) begin
         @(posedge clk);
         cycles++;
         if (cycles >= WATCHDOG_CYCLES) begin
            failures++;
            $display("FAIL watchdog expired after %0d cycles", cycles);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   initial begin
      idle();
      rst = 1'b1;
      step();
      check_now(busy, 32'h0, "rst_busy_direct");
      check_now({26'd0, pend}, 32'h0, "rst_pend_direct");
      check_now({31'd0, err}, 32'h0, "rst_err_direct");
      check_now({31'd0, ready}, 32'h1, "rst_ready_direct");
      // reset then read
      idle(); set_rs(5'd5, 5'd0);
      expect_v(K_RD0, 32'h0, "rst_rd0");
      expect_v(K_RD1, 32'h0, "rst_rd1");
      expect_v(K_BUSY, 32'h0, "rst_busy");
      expect_v(K_PEND, 32'h0, "rst_pend");
      expect_v(K_READY, 32'h1, "rst_ready");
      expect_v(K_ERR, 32'h0, "rst_err");
      step();

      // RAW stall and release
      idle(); issue(5'd5);
      expect_v(K_READY, 32'h1, "raw_issue_ready");
      step();
      idle(); issue_valid = 1'b1; set_rs(5'd5, 5'd0); rs_used = 2'b01;
      expect_v(K_BUSY, 32'h0000_0020, "raw_busy5");
      expect_v(K_PEND, 32'h1, "raw_pend1");
      expect_v(K_READY, 32'h0, "raw_stall");
      expect_v(K_RDY_NB, 32'h0, "raw_stall_nb");
      step();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
      expect_v(K_READY, 32'h1, "raw_bypass_ready");
      expect_v(K_RD0, 32'hDEAD_BEEF, "raw_bypass_data");
      expect_v(K_RDY_NB, 32'h0, "nb_wb_cycle_ready");
      expect_v(K_RD0_NB, 32'h0, "nb_wb_cycle_data");
      step();
      wb_valid = 1'b0; set_rs(5'd5, 5'd5);
      expect_v(K_READY, 32'h1, "raw_after_ready");
      expect_v(K_RD0, 32'hDEAD_BEEF, "raw_array_rd0");
      expect_v(K_RD1, 32'hDEAD_BEEF, "raw_array_rd1");
      expect_v(K_BUSY, 32'h0, "raw_busy_clr");
      expect_v(K_PEND, 32'h0, "raw_pend0");
      expect_v(K_RDY_NB, 32'h1, "nb_after_ready");
      expect_v(K_RD0_NB, 32'hDEAD_BEEF, "nb_array_rd0");
      step();

      // simultaneous set and clear of register 7
      idle(); issue(5'd7);
      step();
      issue(5'd7); wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
      expect_v(K_READY, 32'h1, "setclr_ready");
      expect_v(K_PEND, 32'h1, "setclr_pend_before");
      step();
      idle();
      expect_v(K_BUSY, 32'h0000_0080, "setclr_busy7");
      expect_v(K_PEND, 32'h1, "setclr_pend1");
      expect_v(K_ERR, 32'h0, "setclr_err");
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h78;
      step();
      idle();
      expect_v(K_BUSY, 32'h0, "setclr_busy_clr");
      expect_v(K_PEND, 32'h0, "setclr_pend0");
      step();

      // register 0 and WAW
      idle(); issue(5'd0);
      step();
      idle(); wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
      expect_v(K_BUSY, 32'h0, "x0_busy");
      expect_v(K_PEND, 32'h0, "x0_pend");
      expect_v(K_RD0, 32'h0, "x0_bypass_rd0");
      step();
      idle();
      expect_v(K_RD0, 32'h0, "x0_array_rd0");
      expect_v(K_ERR, 32'h0, "x0_err");
      issue(5'd3);
      step();
      idle(); issue(5'd3);
      expect_v(K_READY, 32'h0, "waw_stall");
      expect_v(K_BUSY, 32'h0000_0008, "waw_busy3");
      expect_v(K_PEND, 32'h1, "waw_pend1");
      step();
      idle(); wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
      step();
      idle();
      expect_v(K_PEND, 32'h0, "waw_pend0");

      // flush and error
      issue(5'd2);
      step();
      issue(5'd4);
      step();
      issue(5'd9);
      step();
      idle(); flush = 1'b1; issue(5'd11);
      expect_v(K_BUSY, 32'h0000_0214, "flush_busy_pre");
      expect_v(K_PEND, 32'h3, "flush_pend3");
      expect_v(K_READY, 32'h0, "flush_ready");
      step();
      idle();
      expect_v(K_BUSY, 32'h0, "flush_busy_clr");
      expect_v(K_PEND, 32'h0, "flush_pend0");
      expect_v(K_ERR, 32'h0, "flush_err0");
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hCAFE_0004;
      step();
      idle(); set_rs(5'd4, 5'd0);
      expect_v(K_ERR, 32'h1, "err_set");
      expect_v(K_RD0, 32'hCAFE_0004, "err_write_done");
      expect_v(K_PEND, 32'h0, "err_pend0");
      step();
      step();
      expect_v(K_ERR, 32'h1, "err_sticky");
      step();
      rst = 1'b1;
      step();
      idle(); set_rs(5'd4, 5'd0);
      expect_v(K_ERR, 32'h0, "err_rst_clr");
      expect_v(K_RD0, 32'h0, "rf_rst_clr");
      step();

      @(negedge clk);
      #1;
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
